sample_mem_mc: RTL and testbench
================================

SAMPLE_MEM_MC -- requirements
Module: sample_mem_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 16: sample width, Q1.15 signed.
REQ-002 Parameter FILTER_TAPS, default 317: filter length, >=2, odd or even; P = ceil(FILTER_TAPS/2) symmetric pairs.
REQ-003 Parameter NUM_CH, default 2: independent channels; CH_W = max(1, clog2(NUM_CH)), K_W = max(1, clog2(P)).
REQ-004 clk  in  1  system clock, 100 MHz; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  sample offered.
REQ-007 in_ready  out  1  block idle, sample accepted when in_valid & in_ready.
REQ-008 in_ch  in  CH_W  channel of offered sample.
REQ-009 x_in  in  DATA_WIDTH signed  offered sample.
REQ-010 flush  in  1  clear fill count of channel in_ch; honoured only when in_ready=1.
REQ-011 x_left, x_right  out  DATA_WIDTH signed  pair x[n-k], x[n-(FILTER_TAPS-1-k)].
REQ-012 pair_valid  out  1  pair outputs valid this cycle.
REQ-013 pair_k  out  K_W  pair index k.
REQ-014 pair_ch  out  CH_W  channel of pair.
REQ-015 pair_centre  out  1  k = (FILTER_TAPS-1)/2 with odd FILTER_TAPS; x_left = x_right, core adds once.
REQ-016 pair_last  out  1  k = P-1.

Function
REQ-017 Storage SHALL be NUM_CH circular buffers of FILTER_TAPS words, synchronous write and synchronous read, BRAM-inferable, not reset.
REQ-018 Each channel SHALL keep write pointer wp[c] (0..FILTER_TAPS-1, wraps to 0 after FILTER_TAPS-1) and fill count fill[c] saturating at FILTER_TAPS.
REQ-019 FSM states IDLE, READ; in_ready = (state == IDLE).
REQ-020 Accept at edge E0: mem[c][wp[c]] <= x_in, newest[c] = wp[c], wp[c] advances, fill[c] increments (saturating), state -> READ with k=0, ch latched.
REQ-021 In READ, each edge Ej (j=1..P) SHALL read pair k=j-1 and increment k; at edge where k=P-1 issued, state -> IDLE.
REQ-022 Left address = (newest - k) mod FILTER_TAPS; right address = (newest + 1 + k) mod FILTER_TAPS; no overflow in intermediate sums (ADDR_W+1 bits).
REQ-023 Latency: pair k visible after edge E(k+1); pair_valid high exactly P consecutive cycles per accepted sample; sample written at E0 SHALL be returned at E1 (write-before-read).
REQ-024 Zero-masking: x_left SHALL read 0 when k >= fill[c]; x_right SHALL read 0 when (FILTER_TAPS-1-k) >= fill[c].
REQ-025 in_ready high in same cycle as last pair; back-to-back accept yields one sample per P+1 cycles, any channel order.
REQ-026 flush with in_ready=1: fill[in_ch] <= 0, wp[in_ch] <= 0; other channels untouched; flush and in_valid together: flush applied first, then sample written at wp=0 with fill=1.
REQ-027 in_valid/flush while in_ready=0 SHALL be ignored (no write, no state change).
REQ-028 pair_centre only possible when FILTER_TAPS odd; for even FILTER_TAPS SHALL remain 0.

Reset
REQ-029 rst low SHALL immediately force state IDLE, all wp and fill 0, k 0, and x_left, x_right, pair_valid, pair_k, pair_ch, pair_centre, pair_last to 0; in_ready 1 after release.
REQ-030 Reset mid-sweep SHALL abandon the sweep with no further pair_valid; memory contents become don't-care, masked by fill=0.

Verification
REQ-031 FILTER_TAPS=5, ch0 write 7 on empty -> pairs (7,0),(0,0),(0,0) centre on k=2, pair_last on k=2, 3 valid cycles.
REQ-032 FILTER_TAPS=5, ch0 writes 1..5 -> after 5th: (5,1),(4,2),(3,3) centre; 6th write 6 wraps wp -> (6,2),(5,3),(4,4).
REQ-033 FILTER_TAPS=4, NUM_CH=2, ch0 writes 1..4, ch1 writes 10..13 interleaved -> ch0 (4,1),(3,2); ch1 (13,10),(12,11); pair_centre always 0; no cross-channel leakage.
REQ-034 Default params, in_valid held high continuously -> accept every 160 cycles, pair_valid 159 cycles each, pair_k 0..158.
REQ-035 rst low at k=50 of a sweep -> pair_valid 0 same cycle; after release write 9 -> (9,0) then zeros.
REQ-036 FILTER_TAPS=5, fill 5 samples, flush ch0, write 8 -> (8,0),(0,0),(0,0); ch1 data unchanged.

Source files
------------

// File: rtl/sample_mem_mc_if.sv
// Sample-in / symmetric-pair-out bus of the multichannel FIR sample memory.
`timescale 1ns/1ps
interface sample_mem_mc_if #(
    parameter int DATA_WIDTH  = 16,
    parameter int FILTER_TAPS = 317,
    parameter int NUM_CH      = 2
);
    localparam int P    = (FILTER_TAPS + 1) / 2;
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int K_W  = (P > 1) ? $clog2(P) : 1;

    logic                         in_valid;
    logic                         in_ready;
    logic                         flush;
    logic [CH_W-1:0]              in_ch;
    logic signed [DATA_WIDTH-1:0] x_in;
    logic signed [DATA_WIDTH-1:0] x_left;
    logic signed [DATA_WIDTH-1:0] x_right;
    logic                         pair_valid;
    logic [K_W-1:0]               pair_k;
    logic [CH_W-1:0]              pair_ch;
    logic                         pair_centre;
    logic                         pair_last;

    modport master (
        output in_valid, flush, in_ch, x_in,
        input  in_ready, x_left, x_right, pair_valid, pair_k, pair_ch, pair_centre, pair_last
    );
    modport slave (
        input  in_valid, flush, in_ch, x_in,
        output in_ready, x_left, x_right, pair_valid, pair_k, pair_ch, pair_centre, pair_last
    );
endinterface

// File: rtl/sample_mem_mc.sv
// Per-channel circular sample history; after each accepted sample it sweeps out the
// P symmetric tap pairs (newest-k, oldest+k), masking slots not yet filled.
`timescale 1ns/1ps
module sample_mem_mc #(
    parameter int DATA_WIDTH  = 16,
    parameter int FILTER_TAPS = 317,
    parameter int NUM_CH      = 2
) (
    input  logic           clk,
    input  logic           rst,
    sample_mem_mc_if.slave bus
);
    localparam int P      = (FILTER_TAPS + 1) / 2;
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int K_W    = (P > 1) ? $clog2(P) : 1;
    localparam int ADDR_W = $clog2(FILTER_TAPS);
    localparam int AW1    = ADDR_W + 1;
    localparam int FILL_W = $clog2(FILTER_TAPS + 1);

    typedef enum logic {IDLE, READ} state_t;
    state_t state, state_nxt;

    logic [NUM_CH-1:0][ADDR_W-1:0] wp;
    logic [NUM_CH-1:0][FILL_W-1:0] fill;
    logic [ADDR_W-1:0]             newest;
    logic [K_W-1:0]                k;
    logic [CH_W-1:0]               ch;
    logic signed [DATA_WIDTH-1:0]  mem [NUM_CH][FILTER_TAPS];

    logic              accept, last_k, lmask, rmask;
    logic [ADDR_W-1:0] wr_addr, wp_inc, laddr, raddr;
    logic [FILL_W-1:0] fill_base, fill_inc;
    logic [AW1-1:0]    lsum, rsum;

    assign bus.in_ready = (state == IDLE);

    always_comb begin
        accept    = (state == IDLE) && bus.in_valid;
        // A flush in the same cycle as a write restarts the channel at slot 0.
        wr_addr   = bus.flush ? '0 : wp[bus.in_ch];
        fill_base = bus.flush ? '0 : fill[bus.in_ch];
        wp_inc    = (wr_addr == ADDR_W'(FILTER_TAPS - 1)) ? '0 : wr_addr + 1'b1;
        fill_inc  = (fill_base == FILL_W'(FILTER_TAPS)) ? fill_base : fill_base + 1'b1;
        lsum      = {1'b0, newest} + AW1'(FILTER_TAPS) - AW1'(k);
        rsum      = {1'b0, newest} + AW1'(k) + 1'b1;
        laddr     = (lsum >= AW1'(FILTER_TAPS)) ? ADDR_W'(lsum - AW1'(FILTER_TAPS)) : lsum[ADDR_W-1:0];
        raddr     = (rsum >= AW1'(FILTER_TAPS)) ? ADDR_W'(rsum - AW1'(FILTER_TAPS)) : rsum[ADDR_W-1:0];
        lmask     = int'(k) >= int'(fill[ch]);
        rmask     = (FILTER_TAPS - 1 - int'(k)) >= int'(fill[ch]);
        last_k    = (k == K_W'(P - 1));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = READ;
            READ:    if (last_k) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (accept) mem[bus.in_ch][wr_addr] <= bus.x_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp              <= '0;
            fill            <= '0;
            newest          <= '0;
            k               <= '0;
            ch              <= '0;
            bus.x_left      <= '0;
            bus.x_right     <= '0;
            bus.pair_valid  <= 1'b0;
            bus.pair_k      <= '0;
            bus.pair_ch     <= '0;
            bus.pair_centre <= 1'b0;
            bus.pair_last   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                if (bus.flush || bus.in_valid) begin
                    wp[bus.in_ch]   <= bus.in_valid ? wp_inc : '0;
                    fill[bus.in_ch] <= bus.in_valid ? fill_inc : '0;
                end
                if (bus.in_valid) begin
                    newest <= wr_addr;
                    ch     <= bus.in_ch;
                end
                k <= '0;
            end else begin
                k <= k + 1'b1;
            end
            bus.pair_valid <= (state == READ);
            if (state == READ) begin
                // The write at the accept edge is already in the array for the first read.
                bus.x_left      <= lmask ? '0 : mem[ch][laddr];
                bus.x_right     <= rmask ? '0 : mem[ch][raddr];
                bus.pair_k      <= k;
                bus.pair_ch     <= ch;
                bus.pair_centre <= (FILTER_TAPS % 2 == 1) && (int'(k) == (FILTER_TAPS - 1) / 2);
                bus.pair_last   <= last_k;
            end
        end
    end
endmodule

// File: tb/tb_sample_mem_mc.sv
// Directed bench: FT=5 vector table, FT=4 channel interleave, default-size timing and reset.
`timescale 1ns/1ps
module tb_sample_mem_mc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sample_mem_mc_if #(.DATA_WIDTH(16), .FILTER_TAPS(5),   .NUM_CH(2)) if5 ();
    sample_mem_mc_if #(.DATA_WIDTH(16), .FILTER_TAPS(4),   .NUM_CH(2)) if4 ();
    sample_mem_mc_if #(.DATA_WIDTH(16), .FILTER_TAPS(317), .NUM_CH(2)) ifd ();

    sample_mem_mc #(.DATA_WIDTH(16), .FILTER_TAPS(5),   .NUM_CH(2)) u5 (.clk(clk), .rst(rst), .bus(if5.slave));
    sample_mem_mc #(.DATA_WIDTH(16), .FILTER_TAPS(4),   .NUM_CH(2)) u4 (.clk(clk), .rst(rst), .bus(if4.slave));
    sample_mem_mc #(.DATA_WIDTH(16), .FILTER_TAPS(317), .NUM_CH(2)) ud (.clk(clk), .rst(rst), .bus(ifd.slave));

    typedef struct {
        int ch, k, l, r;
        bit cen, last, rdy;
        int cyc;
    } rec_t;

    typedef struct {
        bit v, fl;
        int ch, x;
        int el[3];
        int er[3];
    } vec_t;

    rec_t q5[$], q4[$], qd[$];
    int   acc_q[$];
    vec_t tbl[13];

    always @(negedge clk) begin
        if (if5.pair_valid) q5.push_back('{int'(if5.pair_ch), int'(if5.pair_k), int'(if5.x_left),
                                           int'(if5.x_right), if5.pair_centre, if5.pair_last, if5.in_ready, cyc});
        if (if4.pair_valid) q4.push_back('{int'(if4.pair_ch), int'(if4.pair_k), int'(if4.x_left),
                                           int'(if4.x_right), if4.pair_centre, if4.pair_last, if4.in_ready, cyc});
        if (ifd.pair_valid) qd.push_back('{int'(ifd.pair_ch), int'(ifd.pair_k), int'(ifd.x_left),
                                           int'(ifd.x_right), ifd.pair_centre, ifd.pair_last, ifd.in_ready, cyc});
        if (ifd.in_valid && ifd.in_ready) acc_q.push_back(cyc);
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic set_v(input int i, input bit v, input bit fl, input int ch, input int x,
                         input int l0, input int l1, input int l2, input int r0, input int r1, input int r2);
        tbl[i].v = v; tbl[i].fl = fl; tbl[i].ch = ch; tbl[i].x = x;
        tbl[i].el[0] = l0; tbl[i].el[1] = l1; tbl[i].el[2] = l2;
        tbl[i].er[0] = r0; tbl[i].er[1] = r1; tbl[i].er[2] = r2;
    endtask

    function automatic bit rdy(input int inst);
        case (inst)
            0:       return if5.in_ready;
            1:       return if4.in_ready;
            default: return ifd.in_ready;
        endcase
    endfunction

    task automatic drive(input int inst, input bit v, input bit fl, input int ch, input int x);
        case (inst)
            0:       begin if5.in_valid = v; if5.flush = fl; if5.in_ch = ch[0]; if5.x_in = 16'(x); end
            1:       begin if4.in_valid = v; if4.flush = fl; if4.in_ch = ch[0]; if4.x_in = 16'(x); end
            default: begin ifd.in_valid = v; ifd.flush = fl; ifd.in_ch = ch[0]; ifd.x_in = 16'(x); end
        endcase
    endtask

    task automatic send(input int inst, input bit v, input bit fl, input int ch, input int x);
        int n = 0;
        while (!rdy(inst) && n < 1000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 1000) begin
            total++; bad++;
            $display("FAIL send_timeout: inst %0d not ready after %0d cycles", inst, n);
        end
        drive(inst, v, fl, ch, x);
        @(posedge clk); #1;
        drive(inst, 1'b0, 1'b0, ch, x);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, errs;
        drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0); drive(2, 0, 0, 0, 0);

        // FT=5 expected pairs per accepted write (x_left k0..2, x_right k0..2)
        set_v(0,  1, 0, 0, 7,   7,  0,  0,   0,  0,  0);
        set_v(1,  1, 1, 0, 1,   1,  0,  0,   0,  0,  0);
        set_v(2,  1, 0, 0, 2,   2,  1,  0,   0,  0,  0);
        set_v(3,  1, 0, 0, 3,   3,  2,  1,   0,  0,  1);
        set_v(4,  1, 0, 0, 4,   4,  3,  2,   0,  1,  2);
        set_v(5,  1, 0, 0, 5,   5,  4,  3,   1,  2,  3);
        set_v(6,  1, 0, 0, 6,   6,  5,  4,   2,  3,  4);
        set_v(7,  1, 0, 1, 20,  20, 0,  0,   0,  0,  0);
        set_v(8,  1, 0, 1, 21,  21, 20, 0,   0,  0,  0);
        set_v(9,  0, 1, 0, 0,   0,  0,  0,   0,  0,  0);
        set_v(10, 1, 0, 0, 8,   8,  0,  0,   0,  0,  0);
        set_v(11, 1, 0, 1, 22,  22, 21, 20,  0,  0,  20);
        set_v(12, 1, 0, 1, -5,  -5, 22, 21,  0,  20, 21);

        #1;
        chk("rst_ready5", int'(if5.in_ready), 1);
        chk("rst_pv5", int'(if5.pair_valid), 0);
        chk("rst_pv_d", int'(ifd.pair_valid), 0);
        chk("rst_k_d", int'(ifd.pair_k), 0);
        chk("rst_xl_d", int'(ifd.x_left), 0);
        chk("rst_last_d", int'(ifd.pair_last), 0);
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) begin
            q5.delete();
            send(0, tbl[i].v, tbl[i].fl, tbl[i].ch, tbl[i].x);
            repeat (6) @(posedge clk); #1;
            n = tbl[i].v ? 3 : 0;
            chk($sformatf("ft5_v%0d_count", i), q5.size(), n);
            for (int j = 0; j < 3 && j < q5.size(); j++) begin
                chk($sformatf("ft5_v%0d_k%0d_left", i, j), q5[j].l, tbl[i].el[j]);
                chk($sformatf("ft5_v%0d_k%0d_right", i, j), q5[j].r, tbl[i].er[j]);
                chk($sformatf("ft5_v%0d_k%0d_idx", i, j), q5[j].k, j);
                chk($sformatf("ft5_v%0d_k%0d_ch", i, j), q5[j].ch, tbl[i].ch);
                chk($sformatf("ft5_v%0d_k%0d_centre", i, j), int'(q5[j].cen), (j == 2) ? 1 : 0);
                chk($sformatf("ft5_v%0d_k%0d_last", i, j), int'(q5[j].last), (j == 2) ? 1 : 0);
                chk($sformatf("ft5_v%0d_k%0d_ready", i, j), int'(q5[j].rdy), (j == 2) ? 1 : 0);
            end
        end

        // FT=4, two channels written alternately, back to back
        q4.delete();
        for (int i = 0; i < 4; i++) begin
            send(1, 1, 0, 0, i + 1);
            send(1, 1, 0, 1, 10 + i);
        end
        repeat (6) @(posedge clk); #1;
        chk("ft4_count", q4.size(), 16);
        if (q4.size() == 16) begin
            errs = 0;
            for (int i = 0; i < 16; i++)
                if (q4[i].cen || q4[i].ch != (i / 2) % 2 || q4[i].k != i % 2) errs++;
            chk("ft4_centre_ch_k_errs", errs, 0);
            chk("ft4_ch1_first_l", q4[2].l, 10);
            chk("ft4_ch1_first_r", q4[2].r, 0);
            chk("ft4_ch1_first_k1_l", q4[3].l, 0);
            chk("ft4_ch0_k0_l", q4[12].l, 4);
            chk("ft4_ch0_k0_r", q4[12].r, 1);
            chk("ft4_ch0_k1_l", q4[13].l, 3);
            chk("ft4_ch0_k1_r", q4[13].r, 2);
            chk("ft4_ch1_k0_l", q4[14].l, 13);
            chk("ft4_ch1_k0_r", q4[14].r, 10);
            chk("ft4_ch1_k1_l", q4[15].l, 12);
            chk("ft4_ch1_k1_r", q4[15].r, 11);
        end

        // Default size with in_valid held high: one accept per 160 cycles
        qd.delete(); acc_q.delete();
        drive(2, 1, 0, 0, 100);
        repeat (400) @(posedge clk); #1;
        drive(2, 0, 0, 0, 100);
        repeat (200) @(posedge clk); #1;
        chk("d_accepts", acc_q.size(), 3);
        chk("d_pairs", qd.size(), 477);
        if (acc_q.size() == 3 && qd.size() == 477) begin
            chk("d_period1", acc_q[1] - acc_q[0], 160);
            chk("d_period2", acc_q[2] - acc_q[1], 160);
            chk("d_latency", qd[0].cyc - acc_q[0], 2);
            errs = 0;
            for (int i = 0; i < 477; i++) begin
                if (qd[i].k != i % 159) errs++;
                if (qd[i].cyc - qd[0].cyc != i + i / 159) errs++;
                if (qd[i].cen != (qd[i].k == 158) || qd[i].last != (qd[i].k == 158)) errs++;
                if (qd[i].rdy != (qd[i].k == 158)) errs++;
            end
            chk("d_seq_errs", errs, 0);
            chk("d_s1_k0_l", qd[0].l, 100);
            chk("d_s1_k0_r", qd[0].r, 0);
            chk("d_s1_k1_l", qd[1].l, 0);
            chk("d_s2_k1_l", qd[160].l, 100);
            chk("d_s2_k2_l", qd[161].l, 0);
            chk("d_s3_k2_l", qd[320].l, 100);
            chk("d_s3_k3_l", qd[321].l, 0);
            chk("d_s3_last_r", qd[476].r, 0);
        end

        // Reset in the middle of a sweep
        send(2, 1, 0, 0, 55);
        n = 0;
        while (!(ifd.pair_valid && ifd.pair_k == 50) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) begin
            total++; bad++;
            $display("FAIL rst_wait_timeout: pair_k 50 not seen in %0d cycles", n);
        end
        rst = 1'b0;
        #1;
        chk("midrst_pv", int'(ifd.pair_valid), 0);
        chk("midrst_k", int'(ifd.pair_k), 0);
        chk("midrst_xl", int'(ifd.x_left), 0);
        chk("midrst_last", int'(ifd.pair_last), 0);
        chk("midrst_ready", int'(ifd.in_ready), 1);
        repeat (3) @(posedge clk); #1;
        chk("midrst_pv_held", int'(ifd.pair_valid), 0);
        rst = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("postrst_pv", int'(ifd.pair_valid), 0);
        qd.delete();
        send(2, 1, 0, 0, 9);
        repeat (170) @(posedge clk); #1;
        chk("postrst_count", qd.size(), 159);
        if (qd.size() == 159) begin
            chk("postrst_k0_l", qd[0].l, 9);
            chk("postrst_k0_r", qd[0].r, 0);
            errs = 0;
            for (int i = 1; i < 159; i++)
                if (qd[i].l != 0 || qd[i].r != 0) errs++;
            chk("postrst_nonzero", errs, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
